// File: rtl/id_hazard_sched.sv
// ID-stage hazard scheduler: shadows the EX/MEM/WB destinations, decides issue/stall,
// picks the GPR forwarding source per read port and sequences the taken-branch squash.
module id_hazard_sched #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  input  logic             id_we,
  input  logic [4:0]       id_dest,
  input  logic             id_is_load,
  input  logic             id_br_taken,
  input  logic             ex_allow,
  output logic             id_readygo,
  output logic             id_allow,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
  } shadow_t;

  typedef enum logic [0:0] {RUN = 1'b0, SQUASH = 1'b1} br_state_t;

  localparam shadow_t          BUBBLE  = 7'b0000000;
  localparam logic             LAT2    = (LOAD_LAT >= 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  shadow_t          s3_r, s4_r, s5_r;
  br_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic [2:0]       hit1_s, hit2_s;
  logic             stall_s, readygo_s, issue_s, allow_s, flush_s;
  logic [1:0]       fwd1_s, fwd2_s;

  function automatic logic port_hit(input logic re, input logic [4:0] ra, input shadow_t s);
    return re && (ra != 5'd0) && s.v && (s.dst == ra);
  endfunction

  // hit[0]=EX, hit[1]=MEM, hit[2]=WB; the youngest producer wins.
  function automatic logic [1:0] pick_src(input logic [2:0] hit);
    if (hit[0]) return 2'd1;
    else if (hit[1]) return 2'd2;
    else if (hit[2]) return 2'd3;
    else return 2'd0;
  endfunction

  function automatic logic port_stall(input logic [2:0] hit, input logic ld3, input logic ld4);
    return (hit[0] && ld3) || (LAT2 && !hit[0] && hit[1] && ld4);
  endfunction

  // Hazard detection, forwarding select and issue/allow handshake.
  always_comb begin
    hit1_s  = {port_hit(id_re1, id_raddr1, s5_r), port_hit(id_re1, id_raddr1, s4_r),
               port_hit(id_re1, id_raddr1, s3_r)};
    hit2_s  = {port_hit(id_re2, id_raddr2, s5_r), port_hit(id_re2, id_raddr2, s4_r),
               port_hit(id_re2, id_raddr2, s3_r)};
    stall_s = port_stall(hit1_s, s3_r.ld, s4_r.ld) || port_stall(hit2_s, s3_r.ld, s4_r.ld);
    if (reset) begin
      readygo_s = 1'b1;
      fwd1_s    = 2'd0;
      fwd2_s    = 2'd0;
    end else if (id_valid) begin
      readygo_s = !stall_s;
      fwd1_s    = pick_src(hit1_s);
      fwd2_s    = pick_src(hit2_s);
    end else begin
      readygo_s = !stall_s;
      fwd1_s    = 2'd0;
      fwd2_s    = 2'd0;
    end
    issue_s = id_valid && readygo_s && ex_allow;
    allow_s = reset || !id_valid || issue_s;
  end

  // Branch squash sequencer: one flush cycle, then one SQUASH cycle.
  always_comb begin
    state_nxt_s = state_r;
    flush_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (issue_s && id_br_taken && !reset) begin
          state_nxt_s = SQUASH;
          flush_s     = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      SQUASH:  state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Shadow pipe and FSM state; the whole pipe moves only when EX accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_r    <= BUBBLE;
      s4_r    <= BUBBLE;
      s5_r    <= BUBBLE;
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
      if (ex_allow) begin
        s5_r <= s4_r;
        s4_r <= s3_r;
        s3_r <= issue_s ? {1'b1, (id_we ? id_dest : 5'd0), id_is_load} : BUBBLE;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (id_valid && stall_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      if (flush_s && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end
  end

  assign id_readygo = readygo_s;
  assign id_allow   = allow_s;
  assign fwd_sel1   = fwd1_s;
  assign fwd_sel2   = fwd2_s;
  assign if_flush   = flush_s;
  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: doc/id_hazard_sched.md
Name: id_hazard_sched

Overview:
- Hazard scheduler for the ID stage of the 5-stage LoongArch pipeline (IF, ID, EX, MEM, WB).
- Holds a shadow copy of the write-destination state for EX, MEM and WB. Decides each cycle whether the ID instruction may issue (readygo) and selects the forwarding source for both GPR read ports.
- Sequences the one-cycle wrong-path squash after a taken branch.
- Replaces the constant-1 readygo/allow logic in ID. It is the single owner of stall and flush decisions.

Parameters:
LOAD_LAT, 1, stage distance from EX at which load data becomes forwardable (1: from MEM, 2: only from WB)
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_re1  in  1  ID reads port 1 (rj)
id_re2  in  1  ID reads port 2 (rk/rd)
id_raddr1  in  5  port-1 read address
id_raddr2  in  5  port-2 read address
id_we  in  1  ID instruction writes a GPR
id_dest  in  5  ID destination register
id_is_load  in  1  ID instruction is ld.w
id_br_taken  in  1  ID branch resolved taken (already qualified by id_valid)
ex_allow  in  1  EX accepts a new instruction this cycle; the whole shadow pipe advances only when 1
id_readygo  out  1  ID may issue this cycle
id_allow  out  1  ID may accept from IF
fwd_sel1  out  2  port-1 source: 0 regfile, 1 EX, 2 MEM, 3 WB
fwd_sel2  out  2  port-2 source, same encoding
if_flush  out  1  kill the instruction entering ID next edge
stall_cnt  out  CNT_W  cycles with id_valid && !id_readygo
flush_cnt  out  CNT_W  taken-branch squashes

Behaviour:
- Shadow pipe: three entries s3 (EX), s4 (MEM), s5 (WB), each {v, dst[4:0], ld}.
  - On an edge with ex_allow=1: s5<=s4, s4<=s3, and s3<=issue ? {1, id_we?id_dest:0, id_is_load} : bubble {0,0,0}.
  - ex_allow=0: all entries hold.
  - An entry with dst=0 never matches anything.
- Match for port p: id_re_p && raddr_p!=0 && s_k.v && s_k.dst==raddr_p.
- fwd_sel_p = youngest matching stage (s3 before s4 before s5), else 0. Combinational; forced to 0 when id_valid=0.
- Load-use stall:
  - Stall if any port matches s3 with ld=1.
  - When LOAD_LAT=2, also stall if any port matches s4 with ld=1, unless s3 matches the same port first (s3's value wins, and s3 is then checked as above).
- id_readygo = !stall. issue = id_valid && id_readygo && ex_allow.
- id_allow = !id_valid || issue.
- Branch FSM, states RUN and SQUASH:
  - RUN -> SQUASH when issue && id_br_taken. if_flush=1 in that cycle, so the sequential instruction is not latched as valid into ID.
  - SQUASH -> RUN on the next cycle unconditionally. if_flush=0 in SQUASH.
  - id_br_taken while not issuing (stalled): no transition, no flush. The branch re-evaluates when it issues.
  - A taken branch in SQUASH is impossible, because ID holds a squashed bubble; the FSM ignores id_br_taken while in SQUASH.
- Counters:
  - stall_cnt increments on id_valid && stall.
  - flush_cnt increments on the RUN->SQUASH transition.
  - Both saturate at all-ones (no wrap).
- Reset:
  - All shadow entries are cleared to {0,0,0] and the FSM goes to RUN.
  - Counters go to 0 and if_flush=0.
  - With reset=1, id_readygo=1 (empty pipe), id_allow=1, and fwd_sel=0.
  - Reset mid-stall or mid-SQUASH abandons the state immediately.
- Latency: stall, forwarding and flush are same-cycle combinational decisions on registered shadow state. Shadow update takes 1 cycle.

Test Plan:
- Back-to-back dependence: add.w r5 issues, next instruction reads r5 on port 1 -> fwd_sel1=1. One cycle later (advance) fwd_sel1=2, then 3, then 0 once r5 leaves WB.
- Load-use, LOAD_LAT=1: ld.w r4 issues, next instruction reads r4 on port 2 -> id_readygo=0 for exactly 1 cycle with stall_cnt+=1. The instruction then issues with fwd_sel2=2.
- Load-use, LOAD_LAT=2: same sequence -> 2 stall cycles, issue with fwd_sel2=3, stall_cnt=2.
- r0 and priority: read r0 while s3.dst=0 -> fwd_sel=0 and no stall. r7 written in both s3 and s5 -> fwd_sel=1.
- Taken branch: beq issues with id_br_taken=1 -> if_flush=1 for one cycle and flush_cnt=1. The next cycle is SQUASH with if_flush=0, then RUN.
- ex_allow=0 for 3 cycles with a pending match -> shadow entries hold, fwd_sel is stable, and there is no issue. Reset asserted mid-stall -> the next cycle shows id_readygo=1 and both counters at 0.
